// File: rtl/comparator_pkg.sv
// comparator_pkg: shared constants and result encoding for the comparator.
//   CMP_WIDTH  default operand width
//   NIB_W      width of one cmp_nibble slice
//   cmp_res_t  registered compare result
package comparator_pkg;
    localparam int CMP_WIDTH = 8;
    localparam int NIB_W     = 4;
    typedef enum logic [1:0] {CMP_LT, CMP_EQ, CMP_GT} cmp_res_t;
endpackage

// File: rtl/cmp_nibble.sv
// cmp_nibble: unsigned compare of two 4-bit values.
//   a, b  operands
//   gt    a > b
//   eq    a == b
module cmp_nibble
    import comparator_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    output logic             gt,
    output logic             eq
);
    assign gt = a > b;
    assign eq = a == b;
endmodule

// File: rtl/comparator.sv
// comparator: registered signed/unsigned magnitude compare with max/min select.
//   clk, rst            clock, synchronous active-high reset
//   in_valid            qualifies a, b, is_signed
//   is_signed           1 = two's complement, 0 = unsigned
//   a, b                operands
//   out_valid           flags below come from a new compare
//   gt, lt, eq          a > b, a < b, a == b
//   max_out, min_out    larger / smaller operand
module comparator
    import comparator_pkg::*;
#(
    parameter int WIDTH = CMP_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic             gt,
    output logic             lt,
    output logic             eq,
    output logic [WIDTH-1:0] max_out,
    output logic [WIDTH-1:0] min_out
);
    localparam int N = WIDTH / NIB_W;

    logic [WIDTH-1:0] w_a, w_b;
    logic [N-1:0]     w_gt, w_eq;
    cmp_res_t         w_res;
    cmp_res_t         r_res;
    logic             r_done;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_max, r_min;

    // Flipping the MSB maps two's complement order onto unsigned order.
    assign w_a = is_signed ? {~a[WIDTH-1], a[WIDTH-2:0]} : a;
    assign w_b = is_signed ? {~b[WIDTH-1], b[WIDTH-2:0]} : b;

    for (genvar g = 0; g < N; g++) begin : g_nib
        cmp_nibble u_nib (
            .a  (w_a[g*NIB_W +: NIB_W]),
            .b  (w_b[g*NIB_W +: NIB_W]),
            .gt (w_gt[g]),
            .eq (w_eq[g])
        );
    end

    // Walking upward lets the most significant unequal nibble win.
    always_comb begin
        w_res = CMP_EQ;
        for (int i = 0; i < N; i++)
            if (!w_eq[i]) w_res = w_gt[i] ? CMP_GT : CMP_LT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_res       <= CMP_EQ;
            r_done      <= 1'b0;
            r_out_valid <= 1'b0;
            r_max       <= '0;
            r_min       <= '0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_res  <= w_res;
                r_done <= 1'b1;
                r_max  <= (w_res == CMP_LT) ? b : a;
                r_min  <= (w_res == CMP_LT) ? a : b;
            end
        end
    end

    // r_done keeps all flags low until the first compare after reset.
    assign out_valid = r_out_valid;
    assign gt        = r_done && r_res == CMP_GT;
    assign lt        = r_done && r_res == CMP_LT;
    assign eq        = r_done && r_res == CMP_EQ;
    assign max_out   = r_max;
    assign min_out   = r_min;
endmodule

// File: tb/tb_comparator.sv
// tb_comparator: directed table, hold/reset sequences and random model check.
module tb_comparator;
    logic       clk = 0, rst = 1, in_valid = 0, is_signed = 0;
    logic [7:0] a = 0, b = 0;
    logic       out_valid, gt, lt, eq;
    logic [7:0] max_out, min_out;
    int         total = 0, passed = 0;

    comparator #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .is_signed(is_signed),
        .a(a), .b(b), .out_valid(out_valid), .gt(gt), .lt(lt), .eq(eq),
        .max_out(max_out), .min_out(min_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v, sg;
        logic [7:0] a, b;
        logic       ov, g, l, e;
        logic [7:0] mx, mn;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic sg, input logic [7:0] x, input logic [7:0] y);
        in_valid = v; is_signed = sg; a = x; b = y;
    endtask

    task automatic chk_all(input string t, input logic ov, input logic g, input logic l,
                           input logic e, input logic [7:0] mx, input logic [7:0] mn);
        chk({t, ".out_valid"}, 32'(out_valid), 32'(ov));
        chk({t, ".gt"}, 32'(gt), 32'(g));
        chk({t, ".lt"}, 32'(lt), 32'(l));
        chk({t, ".eq"}, 32'(eq), 32'(e));
        chk({t, ".max"}, 32'(max_out), 32'(mx));
        chk({t, ".min"}, 32'(min_out), 32'(mn));
    endtask

    function automatic int val(input logic [7:0] x, input logic sg);
        return sg ? int'($signed(x)) : int'(x);
    endfunction

    initial begin
        logic       mg, ml, me, v, sg;
        logic [7:0] mmx, mmn, x, y;
        tbl[0] = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00};
        tbl[1] = '{1'b1, 1'b0, 8'h03, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 8'h03, 8'h01};
        tbl[2] = '{1'b1, 1'b0, 8'h01, 8'h03, 1'b1, 1'b0, 1'b1, 1'b0, 8'h03, 8'h01};
        tbl[3] = '{1'b1, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 8'h00};
        tbl[4] = '{1'b1, 1'b1, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'hFF};
        tbl[5] = '{1'b1, 1'b0, 8'hAA, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0, 8'hAA, 8'h55};
        tbl[6] = '{1'b1, 1'b1, 8'hAA, 8'h55, 1'b1, 1'b0, 1'b1, 1'b0, 8'h55, 8'hAA};
        tbl[7] = '{1'b1, 1'b1, 8'h80, 8'h7F, 1'b1, 1'b0, 1'b1, 1'b0, 8'h7F, 8'h80};
        tbl[8] = '{1'b1, 1'b1, 8'h7F, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b1, 8'h7F, 8'h7F};

        drive(1, 0, 8'h12, 8'h34);
        tick;
        chk_all("rst_with_valid", 0, 0, 0, 0, 8'h00, 8'h00);
        rst = 0;
        drive(0, 0, 8'h99, 8'h11);
        tick;
        chk_all("idle_after_rst", 0, 0, 0, 0, 8'h00, 8'h00);

        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].v, tbl[i].sg, tbl[i].a, tbl[i].b);
            tick;
            chk_all($sformatf("tbl%0d", i), tbl[i].ov, tbl[i].g, tbl[i].l, tbl[i].e, tbl[i].mx, tbl[i].mn);
        end

        drive(1, 0, 8'h5A, 8'h33);
        tick;
        chk_all("hold_load", 1, 1, 0, 0, 8'h5A, 8'h33);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 8'h01 + 8'(i), 8'hF0);
            tick;
            chk_all($sformatf("hold%0d", i), 0, 1, 0, 0, 8'h5A, 8'h33);
        end

        drive(1, 0, 8'h01, 8'h02);
        tick;
        chk_all("pre_rst", 1, 0, 1, 0, 8'h02, 8'h01);
        rst = 1;
        drive(1, 0, 8'h09, 8'h03);
        tick;
        chk_all("mid_rst", 0, 0, 0, 0, 8'h00, 8'h00);
        rst = 0;
        drive(1, 1, 8'h80, 8'h01);
        tick;
        chk_all("post_rst", 1, 0, 1, 0, 8'h01, 8'h80);

        mg = 0; ml = 1; me = 0; mmx = 8'h01; mmn = 8'h80;
        for (int i = 0; i < 1000; i++) begin
            v  = $urandom_range(0, 7) != 0;
            sg = 1'($urandom_range(0, 1));
            x  = 8'($urandom);
            y  = ($urandom_range(0, 7) == 0) ? x : 8'($urandom);
            drive(v, sg, x, y);
            if (v) begin
                mg = val(x, sg) > val(y, sg);
                ml = val(x, sg) < val(y, sg);
                me = val(x, sg) == val(y, sg);
                mmx = ml ? y : x;
                mmn = ml ? x : y;
            end
            tick;
            chk_all($sformatf("rnd%0d", i), v, mg, ml, me, mmx, mmn);
            chk($sformatf("rnd%0d.onehot", i), 32'($countones({gt, lt, eq})), 32'd1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
